// File: rtl/ccd_pixel_usb_tx.sv
// rtl/ccd_pixel_usb_tx.sv - CCD pixel capture into a word FIFO, serialised low byte first onto an FT245-style USB write port
// Optional 55/AA frame marker on each synchronised ccd_busy rise: define CCD_FRAME_MARKER_EN.
module ccd_pixel_usb_tx #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              ccd_busy,
    input  logic [15:0]       data_in,
    input  logic              data_avail,
    output logic              data_accept,
    input  logic              usb_txe_n,
    output logic              usb_wr_n,
    output logic [7:0]        usb_data,
    output logic [ADDR_W:0]   fifo_level,
    output logic              fifo_full
);

    logic avail_m, avail_s, busy_m, busy_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avail_m <= 1'b0;
            avail_s <= 1'b0;
            busy_m  <= 1'b0;
            busy_s  <= 1'b0;
        end else begin
            avail_m <= data_avail;
            avail_s <= avail_m;
            busy_m  <= ccd_busy;
            busy_s  <= busy_m;
        end
    end

    logic [15:0]     mem [DEPTH];
    logic [ADDR_W:0] wptr, rptr;
    logic [15:0]     head;
    logic            push, pop, fifo_empty;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                        (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign fifo_level = wptr - rptr;
    assign head       = mem[rptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[ADDR_W-1:0]] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    typedef enum logic {CAP_WAIT, CAP_ACK} cap_state_t;
    cap_state_t cap_state, cap_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cap_state <= CAP_WAIT;
        else
            cap_state <= cap_next;
    end

    always_comb begin
        cap_next = cap_state;
        push     = 1'b0;
        case (cap_state)
            CAP_WAIT: begin
                if (enable && avail_s && !fifo_full) begin
                    push     = 1'b1;
                    cap_next = CAP_ACK;
                end
            end
            CAP_ACK: begin
                if (!avail_s)
                    cap_next = CAP_WAIT;
            end
            default: cap_next = CAP_WAIT;
        endcase
    end

    assign data_accept = (cap_state == CAP_ACK);

    logic marker_pend, marker_take;

`ifdef CCD_FRAME_MARKER_EN
    logic busy_d;

    // A rise seen while a marker is still queued (or being taken) collapses into it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_d      <= 1'b0;
            marker_pend <= 1'b0;
        end else begin
            busy_d <= busy_s;
            if (marker_take)
                marker_pend <= 1'b0;
            else if (busy_s && !busy_d)
                marker_pend <= 1'b1;
        end
    end
`else
    logic unused_busy;
    assign marker_pend = 1'b0;
    assign unused_busy = busy_s ^ marker_take;
`endif

    // Any state other than TX_IDLE means usb_data holds a byte awaiting transfer.
    typedef enum logic [2:0] {TX_IDLE, TX_LO, TX_HI, TX_MK1, TX_MK2} tx_state_t;
    tx_state_t  tx_state, tx_next;
    logic [7:0] hi_byte, hi_next, data_next;
    logic       boundary;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            usb_data <= 8'h00;
            hi_byte  <= 8'h00;
        end else begin
            tx_state <= tx_next;
            usb_data <= data_next;
            hi_byte  <= hi_next;
        end
    end

    always_comb begin
        tx_next     = tx_state;
        data_next   = usb_data;
        hi_next     = hi_byte;
        pop         = 1'b0;
        marker_take = 1'b0;
        boundary    = !usb_txe_n &&
                      (tx_state == TX_IDLE || tx_state == TX_HI || tx_state == TX_MK2);
        if (boundary) begin
            if (marker_pend) begin
                tx_next     = TX_MK1;
                data_next   = 8'h55;
                marker_take = 1'b1;
            end else if (!fifo_empty) begin
                tx_next   = TX_LO;
                pop       = 1'b1;
                data_next = head[7:0];
                hi_next   = head[15:8];
            end else begin
                tx_next = TX_IDLE;
            end
        end else if (!usb_txe_n) begin
            case (tx_state)
                TX_LO: begin
                    tx_next   = TX_HI;
                    data_next = hi_byte;
                end
                TX_MK1: begin
                    tx_next   = TX_MK2;
                    data_next = 8'hAA;
                end
                default: tx_next = tx_state;
            endcase
        end
    end

    assign usb_wr_n = (tx_state == TX_IDLE) || usb_txe_n;

endmodule
